// File: rtl/audio_post_mix_if.sv
// Source-level and PCM-output bundle for audio_post_mix.
// master drives the strobe and source levels; slave (the mixer) drives the PCM outputs.
interface audio_post_mix_if;
  logic        sample_ce;
  logic [15:0] tia_in;
  logic [15:0] pokey_in;
  logic [15:0] ym_l_in;
  logic [15:0] ym_r_in;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_valid;

  modport master (
    output sample_ce, tia_in, pokey_in, ym_l_in, ym_r_in,
    input  out_l, out_r, out_valid
  );

  modport slave (
    input  sample_ce, tia_in, pokey_in, ym_l_in, ym_r_in,
    output out_l, out_r, out_valid
  );
endinterface

// File: rtl/audio_post_mix.sv
// Saturating TIA/POKEY/YM mixer with box-car decimation to signed 16-bit L/R PCM.
// Optional DC removal is compiled in when AUDIO_DC_BLOCK_EN is defined.
module audio_post_mix #(
  parameter int DECIM    = 64,
  parameter int DC_SHIFT = 10
) (
  input  logic             clk_sys,
  input  logic             reset,
  audio_post_mix_if.slave  bus
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int AW    = 16 + LOG2D;

  // Clamp a 17-bit signed difference into the signed 16-bit range.
  function automatic logic [15:0] sat_s17_to_s16(input logic [16:0] d);
    logic [15:0] res;
    if (d[16] && !d[15]) begin
      res = 16'h8000;
    end else if (!d[16] && d[15]) begin
      res = 16'h7FFF;
    end else begin
      res = d[15:0];
    end
    return res;
  endfunction

  // Clamp an 18-bit unsigned mix to 16 bits.
  function automatic logic [15:0] sat_u18_to_u16(input logic [17:0] m);
    logic [15:0] res;
    if (m > 18'h0FFFF) begin
      res = 16'hFFFF;
    end else begin
      res = m[15:0];
    end
    return res;
  endfunction

  logic [LOG2D-1:0] r_cnt;
  logic [AW-1:0]    r_acc_l;
  logic [AW-1:0]    r_acc_r;
  logic [15:0]      r_out_l;
  logic [15:0]      r_out_r;
  logic             r_out_valid;

  logic [17:0]      w_mix_l;
  logic [17:0]      w_mix_r;
  logic [15:0]      w_sat_l;
  logic [15:0]      w_sat_r;
  logic [AW-1:0]    w_sum_l;
  logic [AW-1:0]    w_sum_r;
  logic [15:0]      w_avg_l;
  logic [15:0]      w_avg_r;
  logic             w_period_end;
  logic [15:0]      w_out_l;
  logic [15:0]      w_out_r;

  assign w_mix_l      = 18'(bus.tia_in) + 18'(bus.pokey_in) + 18'(bus.ym_l_in);
  assign w_mix_r      = 18'(bus.tia_in) + 18'(bus.pokey_in) + 18'(bus.ym_r_in);
  assign w_sat_l      = sat_u18_to_u16(w_mix_l);
  assign w_sat_r      = sat_u18_to_u16(w_mix_r);
  // The final sample of a period is folded in before the divide, so it never overflows AW.
  assign w_sum_l      = r_acc_l + AW'(w_sat_l);
  assign w_sum_r      = r_acc_r + AW'(w_sat_r);
  assign w_avg_l      = 16'(w_sum_l >> LOG2D);
  assign w_avg_r      = 16'(w_sum_r >> LOG2D);
  assign w_period_end = bus.sample_ce && (r_cnt == LOG2D'(DECIM - 1));

`ifdef AUDIO_DC_BLOCK_EN
  localparam int DW = 16 + DC_SHIFT;

  logic [DW-1:0] r_dc_acc_l;
  logic [DW-1:0] r_dc_acc_r;
  logic [15:0]   w_dc_est_l;
  logic [15:0]   w_dc_est_r;

  assign w_dc_est_l = 16'(r_dc_acc_l >> DC_SHIFT);
  assign w_dc_est_r = 16'(r_dc_acc_r >> DC_SHIFT);
  assign w_out_l    = sat_s17_to_s16({1'b0, w_avg_l} - {1'b0, w_dc_est_l});
  assign w_out_r    = sat_s17_to_s16({1'b0, w_avg_r} - {1'b0, w_dc_est_r});

  // Leaky DC tracker, updated once per output sample from the pre-update estimate.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dc_acc_l <= DW'(0);
      r_dc_acc_r <= DW'(0);
    end else if (w_period_end) begin
      r_dc_acc_l <= r_dc_acc_l + DW'(w_avg_l) - DW'(w_dc_est_l);
      r_dc_acc_r <= r_dc_acc_r + DW'(w_avg_r) - DW'(w_dc_est_r);
    end else begin
      r_dc_acc_l <= r_dc_acc_l;
      r_dc_acc_r <= r_dc_acc_r;
    end
  end
`else
  assign w_out_l = w_avg_l ^ 16'h8000;
  assign w_out_r = w_avg_r ^ 16'h8000;
`endif

  // Decimation counter, accumulators and registered PCM output with one-cycle strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt       <= LOG2D'(0);
      r_acc_l     <= AW'(0);
      r_acc_r     <= AW'(0);
      r_out_l     <= 16'h0000;
      r_out_r     <= 16'h0000;
      r_out_valid <= 1'b0;
    end else if (bus.sample_ce) begin
      r_cnt <= r_cnt + LOG2D'(1);
      if (w_period_end) begin
        r_acc_l     <= AW'(0);
        r_acc_r     <= AW'(0);
        r_out_l     <= w_out_l;
        r_out_r     <= w_out_r;
        r_out_valid <= 1'b1;
      end else begin
        r_acc_l     <= w_sum_l;
        r_acc_r     <= w_sum_r;
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_l     = r_out_l;
  assign bus.out_r     = r_out_r;
  assign bus.out_valid = r_out_valid;

endmodule
